registros_multipuerto: RTL
==========================

# registros_multipuerto

Parametrised integer register file for the RISC-V core, successor to the single-write/dual-read `Registros` bank. It provides `NREAD` combinational read ports, one synchronous write port with optional same-cycle write-to-read bypass, and hardwired-zero x0. It also keeps a per-register busy scoreboard that the decode stage uses to detect pending producers. All architectural state clears on an asynchronous reset.

## Interface
- `XLEN`, 32, data width in bits.
- `NREG`, 32, number of registers; power of two, ≥2.
- `NREAD`, 2, number of read ports, 1..4.
- `BYPASS`, 1, 1 = a read of the register being written returns `wdata` in the same cycle; 0 = it returns the old value.
- `AW`, `$clog2(NREG)`, address width; derived, not overridable.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `we` in 1: write enable; `RegW`-equivalent.
- `waddr` in AW: write address.
- `wdata` in XLEN: write data.
- `raddr` in NREAD*AW: packed read addresses; port i occupies bits [i*AW +: AW].
- `rdata` out NREAD*XLEN: packed read data, same packing.
- `rbusy` out NREAD: port i's register has a pending producer.
- `issue_en` in 1: an instruction with destination `issue_rd` is issued this cycle.
- `issue_rd` in AW: destination of the issuing instruction.
- `busy_cnt` out AW+1: number of busy registers.

## Operation
- Storage is `NREG` entries of `XLEN` bits. Entry 0 is never written and always reads 0.
- Write: on a rising edge with `we=1` and `waddr!=0`, entry[waddr] takes `wdata`. A write to address 0 is silently dropped, with no state change.
- Read port i: `rdata[i]` = 0 if `raddr[i]==0`.
  - Otherwise, if `BYPASS=1` and `we` is asserted with `waddr==raddr[i]`, it returns `wdata`.
  - Otherwise it returns entry[raddr[i]].
  - Reads are purely combinational.
- Scoreboard: one busy bit per register; bit 0 is constant 0.
  - Set: rising edge with `issue_en=1` and `issue_rd!=0`.
  - Clear: rising edge with `we=1` and `waddr` equal to that register.
  - Same register set and cleared in the same edge: set wins (a new producer supersedes the completing one).
  - `issue_rd` already busy: the bit stays set. No error is flagged; the WAW ordering policy belongs to the pipeline.
- `rbusy[i]` = busy[raddr[i]]. If `BYPASS=1` and a write to that address is in progress this cycle, `rbusy[i]=0`, unless the same-cycle issue targets that address.
- `busy_cnt` is the registered population count of the busy bits, updated in the same edge as the bits. It is never greater than NREG-1.
- Multiple read ports may address the same register; each returns identical data.

## Timing
- Reset (`rst_n=0`, asynchronous, no clock needed): all entries = 0, all busy bits = 0, `busy_cnt`=0. Consequently every `rdata`=0 and every `rbusy`=0 while reset is held.
- Reset asserted mid-write: the write is lost. Reset deasserts synchronously relative to use; the first write can land at the first rising edge after `rst_n` rises.
- Write latency: 1 edge. Data is visible to reads in the cycle after the edge, or in the same cycle when `BYPASS=1`.
- Scoreboard latency: 1 edge from issue to `rbusy`, and 1 edge from write to clear. With `BYPASS=1`, the clear is visible combinationally in the write cycle.
- Read latency: 0 cycles, combinational from `raddr`, `we`, `waddr` and `wdata`.
- No handshake on any port; every input is sampled every cycle.

## Structure
- Shared package `rv_regfile_pkg` holds:
  - the `XLEN_DEF=32` and `NREG_DEF=32` constants;
  - the `reg_addr_t` typedef;
  - the `ZERO_REG=0` constant;
  - a popcount function.
- One sub-module: `marcador_ocupado`, the busy-bit array plus `busy_cnt`, with inputs `issue_en`, `issue_rd`, `we` and `waddr`. The storage array and read muxes stay in the top module.

## Test plan
- `we=1`, `waddr=0`, `wdata=50`, one edge; `raddr0=0` -> `rdata0=0`, `busy_cnt=0`.
- `we=1`, `waddr=1`, `wdata=50`, one edge; then `raddr0=1` -> `rdata0=50`. With `BYPASS=1`, `rdata0=50` already in the write cycle; with `BYPASS=0`, 0 until after the edge.
- Write 80 to x5 and 50 to x1, then `raddr0=1`, `raddr1=5` -> `rdata0=50`, `rdata1=80` simultaneously; `NREAD=3` with all three ports on x5 -> all read 80.
- `issue_en=1`, `issue_rd=7` -> `rbusy` for x7 = 1 after the edge, `busy_cnt=1`. Then `we=1`, `waddr=7` together with `issue_en=1`, `issue_rd=7` -> x7 stays busy, `busy_cnt=1`. Then a write alone -> busy clears, `busy_cnt=0`.
- Write 0xDEADBEEF to x31, issue x3; pull `rst_n` low between clock edges -> `rdata` for x31 = 0 and `busy_cnt=0` immediately, without waiting for a clock edge.
- Parameter sweep: `XLEN=64`, `NREG=16`, `NREAD=4`. Write 0xFFFF_FFFF_0000_0001 to x15 -> reads back exactly; x0 still reads 0.

Source files
------------

// File: rtl/rv_regfile_pkg.sv
// Shared definitions for the integer register file and its busy scoreboard.
package rv_regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  // x0 is hardwired to zero and never holds a producer
  localparam int ZERO_REG = 0;

  // Widest bit vector the population count accepts; callers zero-extend
  localparam int POP_MAX = 1024;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX; i++) c += 32'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/marcador_ocupado.sv
// Busy scoreboard: one pending-producer bit per register plus registered count.
module marcador_ocupado
  import rv_regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     busy_cnt
);
  logic [NREG-1:0]    r_busy;
  logic [AW:0]        r_cnt;
  logic [NREG-1:0]    w_busy_nxt;
  logic [POP_MAX-1:0] w_ext;
  logic [AW:0]        w_pop;

  // Next busy vector: a new issue beats a completing write to the same register
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < NREG; r++) begin
      if (issue_en && issue_rd == AW'(r))  w_busy_nxt[r] = 1'b1;
      else if (we && waddr == AW'(r))      w_busy_nxt[r] = 1'b0;
    end
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  // Count of the bits about to be stored, so the count tracks them edge for edge
  always_comb begin
    w_ext              = '0;
    w_ext[NREG-1:0]    = w_busy_nxt;
    w_pop              = (AW+1)'(popcount(w_ext));
  end

  // Scoreboard state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_pop;
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_cnt;
endmodule

// File: rtl/registros_multipuerto.sv
// Integer register file: NREAD combinational reads, one write, x0 = 0, busy scoreboard.
module registros_multipuerto
  import rv_regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREG   = NREG_DEF,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_rd,
  output logic [AW:0]           busy_cnt
);
  logic [NREG-1:0][XLEN-1:0] r_mem;
  logic [NREG-1:0]           w_busy;
  logic                      w_wr_ok;

  assign w_wr_ok = we && (waddr != AW'(ZERO_REG));

  // Storage; entry 0 is never written so it keeps its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_mem        <= '0;
    else if (w_wr_ok) r_mem[waddr] <= wdata;
  end

  marcador_ocupado #(.NREG(NREG)) u_marcador (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .we       (we),
    .waddr    (waddr),
    .busy     (w_busy),
    .busy_cnt (busy_cnt)
  );

  // Per-port read mux with optional write forwarding
  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero, w_hit, w_iss;
    assign w_ra   = raddr[gi*AW +: AW];
    assign w_zero = (w_ra == AW'(ZERO_REG));
    assign w_hit  = (BYPASS != 0) && we && (waddr == w_ra);
    assign w_iss  = issue_en && (issue_rd == w_ra);

    assign rdata[gi*XLEN +: XLEN] = w_zero ? '0 : (w_hit ? wdata : r_mem[w_ra]);
    // A forwarded write completes the producer now, unless a new one issues alongside
    assign rbusy[gi] = w_busy[w_ra] & ~(w_hit & ~w_iss);
  end
endmodule
